// File: rtl/mul_arbiter_if.sv
// Request/grant/result bundle between two operand sources and the shared multiplier.
// Latency: none; this is wiring only.
// Backpressure: a requester holds req until its gnt pulse; results are pulsed, never stalled.
interface mul_arbiter_if #(
  parameter int WIDTH = 6
);
  logic               req0;
  logic [WIDTH-1:0]   a0;
  logic [WIDTH-1:0]   b0;
  logic               req1;
  logic [WIDTH-1:0]   a1;
  logic [WIDTH-1:0]   b1;
  logic               gnt0;
  logic               gnt1;
  logic               done0;
  logic               done1;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  // Operand sources drive requests and operands, observe grants and results.
  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt0, gnt1, done0, done1, product, busy
  );

  // The arbiter/multiplier consumes requests and produces grants and results.
  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt0, gnt1, done0, done1, product, busy
  );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin shares one WIDTH x WIDTH shift-add multiplier between two requesters.
// Latency: gnt one cycle after the accepting edge, done WIDTH+1 cycles after gnt; one op per WIDTH+2 cycles.
// Backpressure: none; requests are ignored while busy and must be held until their gnt pulse.
module mul_arbiter #(
  parameter int WIDTH = 6,
  parameter int CNTW  = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  mul_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WIDTH);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   op_a, op_a_nxt;
  logic [WIDTH-1:0]   op_b, op_b_nxt;
  logic [2*WIDTH:0]   acc, acc_nxt;
  logic [CNTW-1:0]    cnt, cnt_nxt;
  logic               owner, owner_nxt;
  // Requester served most recently; reset to 1 so requester 0 wins the first tie.
  logic               last, last_nxt;
  logic               gnt0, gnt0_nxt;
  logic               gnt1, gnt1_nxt;
  logic               done0, done0_nxt;
  logic               done1, done1_nxt;
  logic [2*WIDTH-1:0] product, product_nxt;
  logic               busy, busy_nxt;

  logic [WIDTH-1:0]   a_shift;
  logic               a_bit;
  logic [2*WIDTH:0]   addend;
  logic [2*WIDTH:0]   acc_sum;
  logic               pick;

  // One shift-add step: add B aligned to the top half when the current multiplier bit is set.
  // The extra accumulator bit keeps the carry before the right shift.
  always_comb begin
    a_shift = op_a >> cnt;
    a_bit   = a_shift[0];
    addend  = a_bit ? {1'b0, op_b, {WIDTH{1'b0}}} : '0;
    acc_sum = acc + addend;
  end

  // Next-state, datapath and registered-output decode for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_nxt   = state;
    op_a_nxt    = op_a;
    op_b_nxt    = op_b;
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    owner_nxt   = owner;
    last_nxt    = last;
    gnt0_nxt    = 1'b0;
    gnt1_nxt    = 1'b0;
    done0_nxt   = 1'b0;
    done1_nxt   = 1'b0;
    product_nxt = product;
    busy_nxt    = busy;
    // On a tie the requester not served last wins; otherwise the sole requester.
    pick        = (bus.req0 && bus.req1) ? ~last : bus.req1;

    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          op_a_nxt  = pick ? bus.a1 : bus.a0;
          op_b_nxt  = pick ? bus.b1 : bus.b0;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          owner_nxt = pick;
          gnt0_nxt  = ~pick;
          gnt1_nxt  = pick;
          busy_nxt  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        acc_nxt = acc_sum >> 1;
        cnt_nxt = cnt + 1'b1;
        if (cnt_nxt == LAST_CNT) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        product_nxt = acc[2*WIDTH-1:0];
        done0_nxt   = ~owner;
        done1_nxt   = owner;
        last_nxt    = owner;
        busy_nxt    = 1'b0;
        state_nxt   = IDLE;
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation without a done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      acc     <= '0;
      cnt     <= '0;
      owner   <= 1'b0;
      last    <= 1'b1;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      product <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      op_a    <= op_a_nxt;
      op_b    <= op_b_nxt;
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      owner   <= owner_nxt;
      last    <= last_nxt;
      gnt0    <= gnt0_nxt;
      gnt1    <= gnt1_nxt;
      done0   <= done0_nxt;
      done1   <= done1_nxt;
      product <= product_nxt;
      busy    <= busy_nxt;
    end
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.done0   = done0;
  assign bus.done1   = done1;
  assign bus.product = product;
  assign bus.busy    = busy;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: reset, single ops, ties, round-robin, zero operands, mid-op reset.
// Latency: each op window is observed cycle by cycle after the accepting edge.
// Backpressure: requests are dropped on their own gnt unless a test holds them.
module tb_mul_arbiter;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  mul_arbiter_if #(.WIDTH(6)) bus ();

  mul_arbiter #(.WIDTH(6), .CNTW(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Per-cycle capture of one observation window.
  logic        r_gnt0  [0:63];
  logic        r_gnt1  [0:63];
  logic        r_done0 [0:63];
  logic        r_done1 [0:63];
  logic        r_busy  [0:63];
  logic [11:0] r_prod  [0:63];

  // Steps n clock edges, sampling 1 time unit after each; unless hold is set, a
  // granted requester drops req and scrambles its operands (latched values must win).
  task automatic record(input int n, input bit hold);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      r_gnt0[i]  = bus.gnt0;
      r_gnt1[i]  = bus.gnt1;
      r_done0[i] = bus.done0;
      r_done1[i] = bus.done1;
      r_busy[i]  = bus.busy;
      r_prod[i]  = bus.product;
      if (!hold) begin
        if (bus.gnt0) begin
          bus.req0 = 1'b0;
          bus.a0   = ~bus.a0;
          bus.b0   = ~bus.b0;
        end
        if (bus.gnt1) begin
          bus.req1 = 1'b0;
          bus.a1   = ~bus.a1;
          bus.b1   = ~bus.b1;
        end
      end
    end
  endtask

  task automatic apply_reset();
    reset_n  = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    apply_reset();
    total++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy} !== 5'b0) begin
      bad++;
      $display("FAIL reset_pulses got=%b want=00000",
               {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy});
    end
    total++;
    if (bus.product !== 12'd0) begin
      bad++;
      $display("FAIL reset_product got=%0d want=0", bus.product);
    end
  endtask

  task automatic test_single_req0();
    bus.a0 = 6'd5; bus.b0 = 6'd7; bus.req0 = 1'b1;
    record(10, 1'b0);
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({r_gnt0[i], r_gnt1[i], r_done0[i], r_done1[i]} !== {i == 0, 1'b0, i == 7, 1'b0}) begin
        bad++;
        $display("FAIL single0_pulses cyc=%0d got=%b want=%b", i,
                 {r_gnt0[i], r_gnt1[i], r_done0[i], r_done1[i]}, {i == 0, 1'b0, i == 7, 1'b0});
      end
      total++;
      if (r_busy[i] !== (i < 7)) begin
        bad++;
        $display("FAIL single0_busy cyc=%0d got=%b want=%b", i, r_busy[i], i < 7);
      end
    end
    total++;
    if (r_prod[6] !== 12'd0) begin
      bad++;
      $display("FAIL single0_prod_before got=%0d want=0", r_prod[6]);
    end
    total++;
    if (r_prod[7] !== 12'd35) begin
      bad++;
      $display("FAIL single0_product got=%0d want=35", r_prod[7]);
    end
  endtask

  task automatic test_max_req1();
    bus.a1 = 6'd63; bus.b1 = 6'd63; bus.req1 = 1'b1;
    record(10, 1'b0);
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({r_gnt0[i], r_gnt1[i], r_done0[i], r_done1[i]} !== {1'b0, i == 0, 1'b0, i == 7}) begin
        bad++;
        $display("FAIL max1_pulses cyc=%0d got=%b want=%b", i,
                 {r_gnt0[i], r_gnt1[i], r_done0[i], r_done1[i]}, {1'b0, i == 0, 1'b0, i == 7});
      end
    end
    total++;
    if (r_prod[7] !== 12'hF81) begin
      bad++;
      $display("FAIL max1_product got=%h want=f81", r_prod[7]);
    end
  endtask

  task automatic test_tie_after_reset();
    apply_reset();
    bus.a0 = 6'd3; bus.b0 = 6'd4; bus.a1 = 6'd6; bus.b1 = 6'd2;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    record(18, 1'b0);
    for (int i = 0; i < 18; i++) begin
      total++;
      if ({r_gnt0[i], r_gnt1[i], r_done0[i], r_done1[i]} !== {i == 0, i == 8, i == 7, i == 15}) begin
        bad++;
        $display("FAIL tie_pulses cyc=%0d got=%b want=%b", i,
                 {r_gnt0[i], r_gnt1[i], r_done0[i], r_done1[i]}, {i == 0, i == 8, i == 7, i == 15});
      end
    end
    total++;
    if (r_prod[7] !== 12'd12) begin
      bad++;
      $display("FAIL tie_product0 got=%0d want=12", r_prod[7]);
    end
    total++;
    if (r_prod[15] !== 12'd12) begin
      bad++;
      $display("FAIL tie_product1 got=%0d want=12", r_prod[15]);
    end
  endtask

  task automatic test_back_to_back();
    bus.a0 = 6'd2; bus.b0 = 6'd9; bus.a1 = 6'd7; bus.b1 = 6'd5;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    record(32, 1'b1);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      int m;
      m = i % 16;
      total++;
      if ({r_gnt0[i], r_gnt1[i], r_done0[i], r_done1[i]} !== {m == 0, m == 8, m == 7, m == 15}) begin
        bad++;
        $display("FAIL b2b_pulses cyc=%0d got=%b want=%b", i,
                 {r_gnt0[i], r_gnt1[i], r_done0[i], r_done1[i]}, {m == 0, m == 8, m == 7, m == 15});
      end
    end
    for (int k = 0; k < 4; k++) begin
      logic [11:0] want;
      want = (k % 2 == 0) ? 12'd18 : 12'd35;
      total++;
      if (r_prod[k*8+7] !== want) begin
        bad++;
        $display("FAIL b2b_product op=%0d got=%0d want=%0d", k, r_prod[k*8+7], want);
      end
    end
    record(4, 1'b0);
  endtask

  task automatic test_zero_operands();
    bus.a0 = 6'd0; bus.b0 = 6'd45; bus.req0 = 1'b1;
    record(10, 1'b0);
    total++;
    if (r_done0[7] !== 1'b1 || r_prod[7] !== 12'd0) begin
      bad++;
      $display("FAIL zero_a_product done=%b got=%0d want=0", r_done0[7], r_prod[7]);
    end
    bus.a1 = 6'd45; bus.b1 = 6'd0; bus.req1 = 1'b1;
    record(10, 1'b0);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (r_prod[i] !== 12'd0) begin
        bad++;
        $display("FAIL zero_hold cyc=%0d got=%0d want=0", i, r_prod[i]);
      end
    end
    total++;
    if (r_done1[7] !== 1'b1 || r_prod[7] !== 12'd0) begin
      bad++;
      $display("FAIL zero_b_product done=%b got=%0d want=0", r_done1[7], r_prod[7]);
    end
  endtask

  task automatic test_reset_mid_run();
    bus.a0 = 6'd5; bus.b0 = 6'd5; bus.req0 = 1'b1;
    record(4, 1'b0);
    total++;
    if (r_gnt0[0] !== 1'b1 || r_busy[3] !== 1'b1) begin
      bad++;
      $display("FAIL midrst_started gnt=%b busy=%b want=1 1", r_gnt0[0], r_busy[3]);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done0, bus.done1} !== 3'b0 || bus.product !== 12'd0) begin
      bad++;
      $display("FAIL midrst_clear busy/done=%b product=%0d want=000 0",
               {bus.busy, bus.done0, bus.done1}, bus.product);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    record(10, 1'b0);
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({r_gnt0[i], r_gnt1[i], r_done0[i], r_done1[i], r_busy[i]} !== 5'b0 || r_prod[i] !== 12'd0) begin
        bad++;
        $display("FAIL midrst_quiet cyc=%0d pulses=%b product=%0d want=00000 0", i,
                 {r_gnt0[i], r_gnt1[i], r_done0[i], r_done1[i], r_busy[i]}, r_prod[i]);
      end
    end
    bus.a0 = 6'd2; bus.b0 = 6'd3; bus.req0 = 1'b1;
    record(10, 1'b0);
    total++;
    if (r_gnt0[0] !== 1'b1 || r_done0[7] !== 1'b1 || r_prod[7] !== 12'd6) begin
      bad++;
      $display("FAIL midrst_after gnt=%b done=%b product=%0d want=1 1 6",
               r_gnt0[0], r_done0[7], r_prod[7]);
    end
  endtask

  initial begin
    clk      = 1'b0;
    reset_n  = 1'b0;
    total    = 0;
    bad      = 0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.a0   = '0;
    bus.b0   = '0;
    bus.a1   = '0;
    bus.b1   = '0;
    #2;
    test_reset();
    test_single_req0();
    test_max_req1();
    test_tie_after_reset();
    test_back_to_back();
    test_zero_operands();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
